// File: rtl/m68k_sdram_controller_pkg.sv
// Shared SDRAM command/state encodings and timing constants for the 68k SDRAM controller.
package m68k_sdram_controller_pkg;

  // {CS_L, RAS_L, CAS_L, WE_L}
  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_NOP       = 4'b0111
  } sdram_cmd_e;

  typedef enum logic [4:0] {
    ST_INIT_WAIT      = 5'd0,
    ST_INIT_PRECHARGE = 5'd1,
    ST_INIT_REFRESH   = 5'd2,
    ST_INIT_MODE      = 5'd3,
    ST_IDLE           = 5'd4,
    ST_REFRESH        = 5'd5,
    ST_RCD            = 5'd6,
    ST_READ_BURST     = 5'd7,
    ST_READ_DTACK     = 5'd8,
    ST_READ_TRP       = 5'd9,
    ST_WRITE_RECOVER  = 5'd10,
    ST_WRITE_DTACK    = 5'd11
  } ctrl_state_e;

  // Burst 8, sequential, CAS latency 2, single-location writes.
  localparam logic [12:0] MODE_WORD = 13'h0223;
  localparam int BURST_LEN      = 8;
  localparam int T_RP           = 2;
  localparam int T_RCD          = 2;
  localparam int T_MRD          = 2;
  localparam int CAS_WAIT       = 3;  // clocks after READ before the first word is sampled
  localparam int WRITE_RECOVERY = 2;  // tWR + tRP NOP clocks before Dtack on a write

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer; raises a sticky request on every wrap.
module sdram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 375
) (
  input  logic Clock,
  input  logic Reset_H,
  input  logic refresh_ack,
  output logic refresh_pending
);

  localparam int CW = $clog2(REFRESH_INTERVAL + 1);

  logic [CW-1:0] count;

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      count           <= '0;
      refresh_pending <= 1'b0;
    end else if (count == CW'(REFRESH_INTERVAL - 1)) begin
      // A wrap wins over a same-cycle acknowledge; wraps while pending collapse into one.
      count           <= '0;
      refresh_pending <= 1'b1;
    end else begin
      count <= count + CW'(1);
      if (refresh_ack) refresh_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/m68k_sdram_controller.sv
// SDRAM controller for the 68k cache: power-up init, auto refresh, 8-word burst reads, single writes.
module m68k_sdram_controller
  import m68k_sdram_controller_pkg::*;
#(
  parameter int INIT_WAIT        = 5000,
  parameter int REFRESH_INTERVAL = 375,
  parameter int T_RC             = 7
) (
  input  logic        Clock,
  input  logic        Reset_H,
  input  logic        DramSelect_L,
  input  logic        AS_L,
  input  logic        WE_L,
  input  logic        UDS_L,
  input  logic        LDS_L,
  input  logic [31:0] Address,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Dtack_L,
  output logic        SDram_CKE_H,
  output logic        SDram_CS_L,
  output logic        SDram_RAS_L,
  output logic        SDram_CAS_L,
  output logic        SDram_WE_L,
  output logic [1:0]  SDram_BA,
  output logic [12:0] SDram_Addr,
  output logic [1:0]  SDram_DQM,
  input  logic [15:0] SDram_DQ_In,
  output logic [15:0] SDram_DQ_Out,
  output logic        SDram_DQ_OE_H,
  output logic [4:0]  ControllerState
);

  ctrl_state_e state;
  sdram_cmd_e  cmd;
  logic [15:0] count;
  logic        init_second;
  logic        refresh_pending;
  logic        refresh_ack;
  logic        access_req;
  logic        access_done;
  logic        unused_addr_bits;

  assign {SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L} = cmd;
  assign ControllerState  = state;
  assign access_req       = !DramSelect_L && !AS_L;
  assign access_done      = AS_L || DramSelect_L;
  assign refresh_ack      = (state == ST_IDLE) && refresh_pending;
  assign unused_addr_bits = ^{Address[31:26], Address[0]};

  sdram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_refresh_timer (
    .Clock           (Clock),
    .Reset_H         (Reset_H),
    .refresh_ack     (refresh_ack),
    .refresh_pending (refresh_pending)
  );

  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      state         <= ST_INIT_WAIT;
      cmd           <= CMD_NOP;
      count         <= '0;
      init_second   <= 1'b0;
      SDram_CKE_H   <= 1'b0;
      SDram_BA      <= '0;
      SDram_Addr    <= '0;
      SDram_DQM     <= 2'b11;
      SDram_DQ_OE_H <= 1'b0;
      SDram_DQ_Out  <= '0;
      DataOut       <= '0;
      Dtack_L       <= 1'b1;
    end else begin
      // NOTE: these defaults make every clock a NOP with DQ released unless a state says otherwise.
      SDram_CKE_H   <= 1'b1;
      cmd           <= CMD_NOP;
      SDram_DQ_OE_H <= 1'b0;
      count         <= count + 16'd1;

      case (state)
        ST_INIT_WAIT:
          if (count == 16'(INIT_WAIT - 1)) begin
            cmd        <= CMD_PRECHARGE;
            SDram_Addr <= 13'h0400;
            count      <= '0;
            state      <= ST_INIT_PRECHARGE;
          end
        ST_INIT_PRECHARGE:
          if (count == 16'(T_RP)) begin
            cmd   <= CMD_REFRESH;
            count <= '0;
            state <= ST_INIT_REFRESH;
          end
        ST_INIT_REFRESH:
          if (count == 16'(T_RC - 1)) begin
            count <= '0;
            if (!init_second) begin
              cmd         <= CMD_REFRESH;
              init_second <= 1'b1;
            end else begin
              cmd        <= CMD_LOAD_MODE;
              SDram_BA   <= '0;
              SDram_Addr <= MODE_WORD;
              state      <= ST_INIT_MODE;
            end
          end
        ST_INIT_MODE:
          if (count == 16'(T_MRD - 1)) state <= ST_IDLE;
        ST_IDLE: begin
          count <= '0;
          if (refresh_pending) begin
            cmd   <= CMD_REFRESH;
            state <= ST_REFRESH;
          end else if (access_req) begin
            cmd        <= CMD_ACTIVE;
            SDram_BA   <= Address[12:11];
            SDram_Addr <= Address[25:13];
            state      <= ST_RCD;
          end
        end
        ST_REFRESH:
          if (count == 16'(T_RC - 2)) state <= ST_IDLE;
        ST_RCD:
          if (count == 16'(T_RCD - 1)) begin
            count <= '0;
            if (!WE_L) begin
              cmd           <= CMD_WRITE;
              SDram_Addr    <= {2'b00, 1'b1, Address[10:1]};
              SDram_DQ_Out  <= DataIn;
              SDram_DQ_OE_H <= 1'b1;
              SDram_DQM     <= {UDS_L, LDS_L};
              state         <= ST_WRITE_RECOVER;
            end else begin
              // Bursts always start on an 8-word boundary.
              cmd        <= CMD_READ;
              SDram_Addr <= {2'b00, 1'b1, Address[10:4], 3'b000};
              SDram_DQM  <= 2'b00;
              state      <= ST_READ_BURST;
            end
          end
        ST_READ_BURST: begin
          if (count >= 16'(CAS_WAIT)) DataOut <= SDram_DQ_In;
          if (count == 16'(CAS_WAIT + BURST_LEN - 1)) begin
            Dtack_L <= 1'b0;
            state   <= ST_READ_DTACK;
          end
        end
        ST_READ_DTACK:
          if (access_done) begin
            Dtack_L   <= 1'b1;
            SDram_DQM <= 2'b11;
            count     <= '0;
            state     <= ST_READ_TRP;
          end
        ST_READ_TRP:
          if (count == 16'(T_RP - 1)) state <= ST_IDLE;
        ST_WRITE_RECOVER: begin
          SDram_DQM <= 2'b11;
          if (count == 16'(WRITE_RECOVERY)) begin
            Dtack_L <= 1'b0;
            state   <= ST_WRITE_DTACK;
          end
        end
        ST_WRITE_DTACK:
          if (access_done) begin
            Dtack_L <= 1'b1;
            state   <= ST_IDLE;
          end
        default: state <= ST_INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_sdram_controller.sv
// Directed bench for m68k_sdram_controller: init, arbitration, write, burst read, mid-burst reset, refresh deferral.
module tb_m68k_sdram_controller;
  import m68k_sdram_controller_pkg::*;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        rst1, rst2;
  logic        DramSelect_L, AS_L, WE_L, UDS_L, LDS_L;
  logic [31:0] Address;
  logic [15:0] DataIn, DQ_In;

  logic [15:0] DataOut, DQ_Out;
  logic        Dtack_L, CKE, CS, RAS, CAS, WEn, OE;
  logic [1:0]  BA, DQM;
  logic [12:0] SAddr;
  logic [4:0]  St;
  logic [3:0]  cmd1;

  logic [15:0] d2_DataOut, d2_DQ_Out;
  logic        d2_Dtack_L, d2_CKE, d2_CS, d2_RAS, d2_CAS, d2_WEn, d2_OE;
  logic [1:0]  d2_BA, d2_DQM;
  logic [12:0] d2_SAddr;
  logic [4:0]  d2_St;
  logic [3:0]  cmd2;

  assign cmd1 = {CS, RAS, CAS, WEn};
  assign cmd2 = {d2_CS, d2_RAS, d2_CAS, d2_WEn};

  m68k_sdram_controller #(.INIT_WAIT(10), .REFRESH_INTERVAL(64), .T_RC(7)) u_dut (
    .Clock(Clock), .Reset_H(rst1), .DramSelect_L(DramSelect_L), .AS_L(AS_L), .WE_L(WE_L),
    .UDS_L(UDS_L), .LDS_L(LDS_L), .Address(Address), .DataIn(DataIn), .DataOut(DataOut),
    .Dtack_L(Dtack_L), .SDram_CKE_H(CKE), .SDram_CS_L(CS), .SDram_RAS_L(RAS), .SDram_CAS_L(CAS),
    .SDram_WE_L(WEn), .SDram_BA(BA), .SDram_Addr(SAddr), .SDram_DQM(DQM), .SDram_DQ_In(DQ_In),
    .SDram_DQ_Out(DQ_Out), .SDram_DQ_OE_H(OE), .ControllerState(St)
  );

  m68k_sdram_controller #(.INIT_WAIT(10), .REFRESH_INTERVAL(4), .T_RC(2)) u_dut2 (
    .Clock(Clock), .Reset_H(rst2), .DramSelect_L(DramSelect_L), .AS_L(AS_L), .WE_L(WE_L),
    .UDS_L(UDS_L), .LDS_L(LDS_L), .Address(Address), .DataIn(DataIn), .DataOut(d2_DataOut),
    .Dtack_L(d2_Dtack_L), .SDram_CKE_H(d2_CKE), .SDram_CS_L(d2_CS), .SDram_RAS_L(d2_RAS),
    .SDram_CAS_L(d2_CAS), .SDram_WE_L(d2_WEn), .SDram_BA(d2_BA), .SDram_Addr(d2_SAddr),
    .SDram_DQM(d2_DQM), .SDram_DQ_In(DQ_In), .SDram_DQ_Out(d2_DQ_Out), .SDram_DQ_OE_H(d2_OE),
    .ControllerState(d2_St)
  );

  // Clocks since reset release, per instance.
  int unsigned cyc1, cyc2;
  always @(posedge Clock or posedge rst1) if (rst1) cyc1 <= 0; else cyc1 <= cyc1 + 1;
  always @(posedge Clock or posedge rst2) if (rst2) cyc2 <= 0; else cyc2 <= cyc2 + 1;

  typedef struct packed {
    logic [12:0] addr;
    logic [1:0]  ba;
    logic [15:0] dq;
    logic [1:0]  dqm;
  } wr_exp_t;

  logic [15:0] rd_q[$];
  wr_exp_t     wr_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  task automatic idle_inputs();
    DramSelect_L = 1'b1; AS_L = 1'b1; WE_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    Address = '0; DataIn = '0; DQ_In = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cke"},   CKE, 0);
    check({tag, "_cmd"},   cmd1, CMD_NOP);
    check({tag, "_ba"},    BA, 0);
    check({tag, "_addr"},  SAddr, 0);
    check({tag, "_dqm"},   DQM, 2'b11);
    check({tag, "_oe"},    OE, 0);
    check({tag, "_dqout"}, DQ_Out, 0);
    check({tag, "_dout"},  DataOut, 0);
    check({tag, "_dtack"}, Dtack_L, 1);
    check({tag, "_state"}, St, ST_INIT_WAIT);
  endtask

  // Expects PRECHARGE@10, REFRESH@13, REFRESH@20, LOAD MODE@27, then Idle.
  task automatic check_init(input string tag);
    int          ev_cyc[$];
    logic [3:0]  ev_cmd[$];
    logic [12:0] ev_addr[$];
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) check({tag, "_cke_first_clock"}, CKE, 1);
      if (cmd1 != CMD_NOP) begin
        ev_cyc.push_back(cyc1);
        ev_cmd.push_back(cmd1);
        ev_addr.push_back(SAddr);
      end
    end
    check({tag, "_cmd_count"}, ev_cyc.size(), 4);
    if (ev_cyc.size() == 4) begin
      check({tag, "_pre_clock"}, ev_cyc[0], 10);
      check({tag, "_pre_cmd"},   ev_cmd[0], CMD_PRECHARGE);
      check({tag, "_pre_a10"},   ev_addr[0][10], 1);
      check({tag, "_ref1_clock"}, ev_cyc[1], 13);
      check({tag, "_ref1_cmd"},   ev_cmd[1], CMD_REFRESH);
      check({tag, "_ref2_clock"}, ev_cyc[2], 20);
      check({tag, "_ref2_cmd"},   ev_cmd[2], CMD_REFRESH);
      check({tag, "_lmr_clock"},  ev_cyc[3], 27);
      check({tag, "_lmr_cmd"},    ev_cmd[3], CMD_LOAD_MODE);
      check({tag, "_lmr_addr"},   ev_addr[3], 13'h0223);
    end
    check({tag, "_idle"}, St, ST_IDLE);
  endtask

  // Read request; DQ words pushed as driven, popped when they reach DataOut. Returns early at abort_at.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [12:0] row,
                         input logic [1:0] ba, input logic [12:0] rd_addr, input int abort_at);
    int          waited;
    logic [15:0] w;
    waited = 0;
    Address = addr; WE_L = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0; DramSelect_L = 1'b0; AS_L = 1'b0;
    do begin
      step();
      waited++;
    end while (cmd1 != CMD_ACTIVE && waited < 60);
    check({tag, "_active"}, cmd1, CMD_ACTIVE);
    check({tag, "_row"},    SAddr, row);
    check({tag, "_bank"},   BA, ba);
    step();
    check({tag, "_trcd_nop"}, cmd1, CMD_NOP);
    step();
    check({tag, "_read_cmd"}, cmd1, CMD_READ);
    check({tag, "_read_col"}, SAddr, rd_addr);
    check({tag, "_read_dqm"}, DQM, 2'b00);
    check({tag, "_read_oe"},  OE, 0);
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i >= 4) begin
        w = rd_q.pop_front();
        check($sformatf("%s_word%0d", tag, i - 4), DataOut, w);
      end
      if (i == abort_at) return;
      if (i == 10) check({tag, "_dtack_busy"}, Dtack_L, 1);
      if (i == 11) check({tag, "_dtack_done"}, Dtack_L, 0);
      if (i >= 3 && i <= 10) begin
        w = 16'($urandom_range(0, 16'hFFFF));
        DQ_In = w;
        rd_q.push_back(w);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          quiet;
    int          waited;
    int          in_access_refresh;
    int          f_cyc, s_cyc, w_cyc, exp_s;
    logic [3:0]  first_cmd;
    wr_exp_t     we;

    idle_inputs();
    rst1 = 1'b1; rst2 = 1'b1;
    step(); step();
    check_reset("reset");
    rst1 = 1'b0;
    check_init("init");

    // Write coinciding with the first refresh wrap (clock 64): refresh goes first.
    while (cyc1 < 64) step();
    Address = 32'h0000_4C82; DataIn = 16'hBEEF; WE_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b1;
    DramSelect_L = 1'b0; AS_L = 1'b0;
    wr_q.push_back('{addr: 13'h0641, ba: 2'b01, dq: 16'hBEEF, dqm: 2'b01});
    step();
    check("arb_refresh_first", cmd1, CMD_REFRESH);
    quiet = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (cmd1 != CMD_NOP) quiet++;
    end
    check("arb_trc_nops", quiet, 0);
    step();
    check("arb_active_after_trc", cmd1, CMD_ACTIVE);
    check("wr_row", SAddr, 13'd2);
    check("wr_bank", BA, 2'b01);
    step();
    check("wr_trcd_nop", cmd1, CMD_NOP);
    step();
    we = wr_q.pop_front();
    check("wr_cmd", cmd1, CMD_WRITE);
    check("wr_col", SAddr, we.addr);
    check("wr_cmd_bank", BA, we.ba);
    check("wr_data", DQ_Out, we.dq);
    check("wr_dqm", DQM, we.dqm);
    check("wr_oe", OE, 1);
    step();
    check("wr_oe_one_clock", OE, 0);
    check("wr_dqm_one_clock", DQM, 2'b11);
    check("wr_dtack_busy", Dtack_L, 1);
    step();
    check("wr_dtack_busy2", Dtack_L, 1);
    step();
    check("wr_dtack_low", Dtack_L, 0);
    AS_L = 1'b1; DramSelect_L = 1'b1; WE_L = 1'b1;
    step();
    check("wr_dtack_release", Dtack_L, 1);

    // Full burst read at 0x2A36: row 1, bank 1, aligned column 0x118 with auto-precharge.
    do_read("rd", 32'h0000_2A36, 13'd1, 2'b01, 13'h0518, 0);
    step();
    check("rd_dtack_hold1", Dtack_L, 0);
    step();
    check("rd_dtack_hold2", Dtack_L, 0);
    AS_L = 1'b1; DramSelect_L = 1'b1; DQ_In = '0;
    step();
    check("rd_dtack_release", Dtack_L, 1);
    step(); step(); step();

    // Reset during burst word 4, then the whole init reruns.
    do_read("rd_abort", 32'h0000_2A36, 13'd1, 2'b01, 13'h0518, 8);
    rst1 = 1'b1;
    #1;
    check_reset("midburst_reset");
    idle_inputs();
    rd_q.delete();
    step();
    rst1 = 1'b0;
    check_init("reinit");

    // Short refresh interval with a long read: refresh deferred, then only one.
    rst1 = 1'b1;
    step();
    rst2 = 1'b0;
    Address = 32'h0000_2A36; WE_L = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0;
    DramSelect_L = 1'b0; AS_L = 1'b0;
    waited = 0;
    do begin
      step();
      waited++;
    end while (cmd2 != CMD_ACTIVE && waited < 80);
    check("d2_active", cmd2, CMD_ACTIVE);
    in_access_refresh = 0;
    waited = 0;
    do begin
      step();
      waited++;
      if (cmd2 == CMD_REFRESH) in_access_refresh++;
    end while (d2_Dtack_L != 1'b0 && waited < 40);
    check("d2_dtack", d2_Dtack_L, 0);
    check("d2_no_refresh_in_access", in_access_refresh, 0);
    AS_L = 1'b1; DramSelect_L = 1'b1;
    f_cyc = -1; s_cyc = -1; first_cmd = CMD_NOP;
    for (int k = 0; k < 40; k++) begin
      step();
      if (cmd2 != CMD_NOP && first_cmd == CMD_NOP) first_cmd = cmd2;
      if (cmd2 == CMD_REFRESH) begin
        if (f_cyc < 0) f_cyc = int'(cyc2);
        else if (s_cyc < 0) s_cyc = int'(cyc2);
      end
    end
    check("d2_first_after_access", first_cmd, CMD_REFRESH);
    // Next refresh needs a fresh wrap (every 4th clock) and T_RC=2 spacing.
    w_cyc = ((f_cyc + 3) / 4) * 4;
    exp_s = (w_cyc + 1 > f_cyc + 2) ? w_cyc + 1 : f_cyc + 2;
    check("d2_second_refresh_clock", s_cyc, exp_s);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
